cic_decimator: RTL and testbench
================================

# cic_decimator

Decimation stage that sits directly downstream of the 8-bit moving-average (comb/integrator) filter. It consumes the filter's per-cycle output samples and performs integrate-and-dump decimation by R = 2^DEC_LOG2, normalising each block sum back to 8 bits. Results are buffered in a small FIFO and presented with a valid/ready handshake to the next consumer. The filter side has no back-pressure, so results that arrive while the FIFO is full are dropped and counted.

## Interface
- DEC_LOG2, default 2: log2 of the decimation ratio; legal range 0..4 (R = 1..16).
- FIFO_DEPTH, default 4: output FIFO entries; power of two, 2..16.
- clk_i, input, 1: single clock; all logic on posedge.
- rstn_i, input, 1: reset is synchronous and active-low.
- x_i, input, 8: unsigned sample from the upstream filter.
- x_valid_i, input, 1: x_i is valid this cycle; no ready is returned upstream.
- y_o, output, 8: unsigned decimated sample at the FIFO head.
- y_valid_o, output, 1: FIFO is not empty.
- y_ready_i, input, 1: consumer accepts y_o when y_valid_o && y_ready_i.
- drop_cnt_o, output, 8: saturating count of dropped results.

## Operation
- Accumulator width is 8+DEC_LOG2 bits and unsigned; it never overflows because 255·R fits.
- Phase counter `ph` is DEC_LOG2 bits wide. It advances only on x_valid_i and wraps from R-1 to 0.
- When x_valid_i is high and ph < R-1: acc <= acc + x_i.
- When x_valid_i is high and ph == R-1 (the dump):
  - sum = acc + x_i.
  - acc <= 0.
  - res = sum >> DEC_LOG2, with rounding per Configuration.
  - res is pushed into the FIFO.
- DEC_LOG2 = 0: every valid sample is pushed unchanged and no rounding is applied.
- Cycles with x_valid_i low leave acc and ph unchanged. Gaps do not break a block.
- FIFO push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise res is discarded and drop_cnt_o increments, saturating at 255.
  - acc and ph still reset and wrap on a dropped dump.
- Pop happens when y_valid_o && y_ready_i. y_o is the head entry and is stable while y_valid_o is high and no pop occurs.
- Simultaneous push and pop on an empty FIFO is not possible, because y_valid_o is low.
- Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- Reset while rstn_i is low at a posedge:
  - acc = 0, ph = 0, FIFO emptied, drop_cnt_o = 0.
  - A partial block in progress is discarded.

## Timing
- Reset values of outputs: y_valid_o = 0, y_o = 0, drop_cnt_o = 0.
- Latency: a dump sample accepted at edge N appears in the FIFO after edge N. y_valid_o is high in cycle N+1 if the FIFO was empty. There is no combinational bypass from x_i to y_o.
- y_ready_i affects only the pop. There are no combinational paths from y_ready_i to y_valid_o or y_o.
- Full throughput is one result per R valid input samples. A consumer holding y_ready_i high never causes drops.
- Register all outputs. y_o may be read from registered FIFO storage selected by a registered read pointer.

## Configuration
- CIC_DEC_ROUND_EN defined: res = (sum + 2^(DEC_LOG2-1)) >> DEC_LOG2, i.e. round half up. The maximum (255·R + R/2) >> DEC_LOG2 = 255, so no saturation logic is needed. The macro has no effect when DEC_LOG2 = 0.
- CIC_DEC_ROUND_EN undefined: res = sum >> DEC_LOG2, i.e. truncation. No rounding adder is present.

## Test plan
- Constant input, y_ready_i = 1: x_i = 100 valid every cycle with defaults → y_o = 100 once every 4 valid samples; first y_valid_o is 1 cycle after the 4th sample; drop_cnt_o = 0.
- Rounding, DEC_LOG2 = 2: samples 1,2,2,2 (sum 7) → y_o = 1 without CIC_DEC_ROUND_EN, y_o = 2 with it. Samples 255 ×4 → y_o = 255 in both builds.
- Valid gaps: samples 10,20,30,40 with 0–3 idle cycles between each → exactly one result of 25, emitted 1 cycle after the sample 40 edge.
- Back-pressure, y_ready_i = 0: 5 blocks of constant 8 → FIFO holds 4 entries of 8 and drop_cnt_o = 1.
  - Then raise y_ready_i → 4 pops of 8, then y_valid_o = 0.
  - Repeating the overflow 300 times → drop_cnt_o saturates at 255.
- Full FIFO with simultaneous pop and dump: FIFO full, y_ready_i = 1 on the dump cycle → no drop, level stays 4, and the new result is last out.
- Reset mid-block: 2 samples of 50, assert rstn_i low for 1 cycle, then 4 samples of 60 → single result 60; y_valid_o = 0 and drop_cnt_o = 0 directly after reset.

Source files
------------

// File: rtl/cic_decimator.sv
// Integrate-and-dump decimator by R = 2**DEC_LOG2 with 8-bit normalised results and a small output FIFO.
// Optional round-half-up normalisation is enabled by defining CIC_DEC_ROUND_EN.
module cic_decimator #(
  parameter int unsigned DEC_LOG2   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] x_i,
  input  logic       x_valid_i,
  output logic [7:0] y_o,
  output logic       y_valid_o,
  input  logic       y_ready_i,
  output logic [7:0] drop_cnt_o
);

  localparam int unsigned R  = 1 << DEC_LOG2;
  localparam int unsigned AW = 8 + DEC_LOG2;
  localparam int unsigned PW = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int unsigned FA = $clog2(FIFO_DEPTH);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0]    res;
  logic          last_ph, dump;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [FA-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FA:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [7:0]    drop_q, drop_d;
  logic          pop, push, full;

  assign last_ph = (ph_q == PW'(R - 1));
  assign dump    = x_valid_i && last_ph;
  assign sum     = acc_q + AW'(x_i);

`ifdef CIC_DEC_ROUND_EN
  // R/2 is zero when R == 1, so the pass-through case needs no special handling.
  logic [AW-1:0] rnd;
  assign rnd = sum + AW'(R / 2);
  assign res = 8'(rnd >> DEC_LOG2);
`else
  assign res = 8'(sum >> DEC_LOG2);
`endif

  always_comb begin
    acc_d    = acc_q;
    ph_d     = ph_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    pop      = valid_q && y_ready_i;
    full     = (count_q == (FA + 1)'(FIFO_DEPTH));
    push     = dump && (!full || pop);

    if (x_valid_i) begin
      acc_d = last_ph ? '0 : sum;
      ph_d  = last_ph ? '0 : ph_q + 1'b1;
    end
    if (dump && !push && drop_q != '1) drop_d = drop_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      acc_q    <= '0;
      ph_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      acc_q    <= acc_d;
      ph_q     <= ph_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
      if (push) mem_q[wr_ptr_q] <= res;
    end
  end

  assign y_o        = mem_q[rd_ptr_q];
  assign y_valid_o  = valid_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: directed scenarios plus random traffic against a block-sum/queue model.
module tb_cic_decimator;
  localparam int DL    = 2;
  localparam int R     = 1 << DL;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn_i;
  logic [7:0] x_i;
  logic       x_valid_i;
  logic [7:0] y_o;
  logic       y_valid_o;
  logic       y_ready_i;
  logic [7:0] drop_cnt_o;

  always #5 clk = ~clk;

  cic_decimator #(.DEC_LOG2(DL), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .x_i(x_i), .x_valid_i(x_valid_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .drop_cnt_o(drop_cnt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int q[$];
  int blk_sum, blk_n, drops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_res(input int s);
`ifdef CIC_DEC_ROUND_EN
    return (s + R / 2) / R;
`else
    return s / R;
`endif
  endfunction

  task automatic cyc(input int x, input bit v, input bit rdy);
    bit pop;
    x_i = 8'(x); x_valid_i = v; y_ready_i = rdy;
    pop = rdy && (q.size() > 0);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (v) begin
      blk_sum += x;
      blk_n++;
      if (blk_n == R) begin
        if (q.size() < DEPTH) q.push_back(model_res(blk_sum));
        else if (drops < 255) drops++;
        blk_sum = 0;
        blk_n   = 0;
      end
    end
    check("y_valid", y_valid_o, 32'(q.size() != 0));
    if (q.size() != 0) check("y_data", y_o, q[0]);
    check("drop_cnt", drop_cnt_o, drops);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; x_valid_i = 1'b0; y_ready_i = 1'b0; x_i = '0;
    @(posedge clk); #1;
    rstn_i = 1'b1;
    q.delete(); blk_sum = 0; blk_n = 0; drops = 0;
    check("rst_valid", y_valid_o, 0);
    check("rst_y", y_o, 0);
    check("rst_drop", drop_cnt_o, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1'b0, 1'b1);
  endtask

  initial begin
    int exp7;
    do_reset();

    // Constant 100 with consumer always ready.
    for (int i = 0; i < 16; i++) begin
      cyc(100, 1'b1, 1'b1);
      if (i == 2) check("const_not_yet", y_valid_o, 0);
      if (i == 3) check("const_first", y_valid_o, 1);
    end
    drain();

    // Rounding vs truncation on sum 7, then full-scale input.
`ifdef CIC_DEC_ROUND_EN
    exp7 = 2;
`else
    exp7 = 1;
`endif
    cyc(1, 1'b1, 1'b0); cyc(2, 1'b1, 1'b0); cyc(2, 1'b1, 1'b0); cyc(2, 1'b1, 1'b0);
    check("round_sum7", y_o, exp7);
    drain();
    for (int i = 0; i < 4; i++) cyc(255, 1'b1, 1'b0);
    check("full_scale", y_o, 255);
    drain();

    // Valid gaps inside one block.
    for (int s = 1; s <= 4; s++) begin
      cyc(10 * s, 1'b1, 1'b0);
      if (s < 4) for (int g = 0; g < int'($urandom_range(0, 3)); g++) cyc($urandom_range(0, 255), 1'b0, 1'b0);
    end
    check("gap_valid", y_valid_o, 1);
    check("gap_result", y_o, 25);
    drain();

    // Back-pressure: five blocks into a four-entry FIFO.
    do_reset();
    for (int i = 0; i < 5 * R; i++) cyc(8, 1'b1, 1'b0);
    check("bp_drop", drop_cnt_o, 1);
    for (int i = 0; i < 4; i++) begin
      check("bp_pop_data", y_o, 8);
      cyc(0, 1'b0, 1'b1);
    end
    check("bp_empty", y_valid_o, 0);

    // Full FIFO with a pop on the dump cycle.
    do_reset();
    for (int b = 1; b <= 4; b++) for (int i = 0; i < R; i++) cyc(11 * b, 1'b1, 1'b0);
    for (int i = 0; i < R - 1; i++) cyc(55, 1'b1, 1'b0);
    cyc(55, 1'b1, 1'b1);
    check("fp_drop", drop_cnt_o, 0);
    check("fp_head", y_o, 22);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1);
    check("fp_last", y_o, 55);
    drain();

    // Repeated overflow saturates the drop counter.
    for (int i = 0; i < (300 + DEPTH) * R; i++) cyc($urandom_range(0, 255), 1'b1, 1'b0);
    check("drop_sat", drop_cnt_o, 255);

    // Reset discards a partial block.
    do_reset();
    cyc(50, 1'b1, 1'b0); cyc(50, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(60, 1'b1, 1'b0);
    check("rst_block", y_o, 60);
    cyc(0, 1'b0, 1'b1);
    check("rst_single", y_valid_o, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 255), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
